// File: rtl/powlib_pkg.sv
// -----------------------------------------------------------------------------
// powlib_pkg
// Shared definitions for the stream library: the default payload type carried
// on a `stream` link and the width helpers used to size pointers and
// occupancy counters for an arbitrary (non-power-of-two) depth.
// No ports.
// -----------------------------------------------------------------------------
package powlib_pkg;

    // Default payload of a stream beat.
    typedef logic [31:0] stream_data_t;

    // Width of an address into a memory of `depth` entries (at least 1 bit).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of a level counter that must hold 0..depth+1.
    function automatic int lvl_w(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/stream.sv
// -----------------------------------------------------------------------------
// stream
// Valid/ready beat link. A beat transfers on a clock edge where valid and
// ready are both high.
//   data  : payload of type T
//   valid : producer has a beat on data
//   ready : consumer can take the beat
// Modports:
//   send    - producer side (drives data/valid, observes ready)
//   receive - consumer side (observes data/valid, drives ready)
// -----------------------------------------------------------------------------
interface stream
    import powlib_pkg::*;
#(
    parameter type T = stream_data_t
) ();

    T     data;
    logic valid;
    logic ready;

    modport send    (output data, output valid, input  ready);
    modport receive (input  data, input  valid, output ready);

endinterface

// File: rtl/sdpram.sv
// -----------------------------------------------------------------------------
// sdpram
// Simple dual-port RAM: one write port, one read port with a registered,
// enable-gated output. Coded in the plain inferable template so block RAM is
// used on FPGA targets.
//   clock     : clock
//   wr_en_i   : write strobe
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_en_i   : read strobe; rd_data_o only changes when this is high
//   rd_addr_i : read address
//   rd_data_o : registered read data
// -----------------------------------------------------------------------------
module sdpram
    import powlib_pkg::*;
#(
    parameter type T     = stream_data_t,
    parameter int  DEPTH = 32,
    localparam int AW    = ptr_w(DEPTH)
) (
    input  logic          clock,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  T              wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output T              rd_data_o
);

    T mem [DEPTH];

    // NOTE: the array has no reset; clearing it would stop block-RAM
    // inference, and the pointers/fill counter already mark entries invalid.
    always_ff @(posedge clock) begin
        // NOTE: clocked state is always assigned with <= so every register
        // samples the pre-edge values regardless of statement order.
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clock) begin
        if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/stream_fifo.sv
// -----------------------------------------------------------------------------
// stream_fifo
// Single-clock stream FIFO of DEPTH memory entries plus one output register
// (capacity DEPTH+1). Optional bypass loads a beat straight into the output
// register when the memory is empty, giving latency 1 instead of 2.
//   clock        : clock
//   reset        : synchronous, active-low reset
//   flush        : synchronous clear of all contents (higher than normal ops)
//   receiver     : input beats (stream.receive), ready is registered
//   sender       : output beats (stream.send)
//   level        : words held = memory fill + sender.valid
//   almost_full  : level >= AFULL
//   almost_empty : level <= AEMPTY
// -----------------------------------------------------------------------------
module stream_fifo
    import powlib_pkg::*;
#(
    parameter type T      = stream_data_t,
    parameter int  DEPTH  = 32,
    parameter int  BYPASS = 0,
    parameter int  AFULL  = DEPTH - 1,
    parameter int  AEMPTY = 1,
    localparam int PW     = ptr_w(DEPTH),
    localparam int LW     = lvl_w(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    stream.receive        receiver,
    stream.send           sender,
    output logic [LW-1:0] level,
    output logic          almost_full,
    output logic          almost_empty
);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] fill_q,   fill_d;
    logic          valid_q,  valid_d;
    logic          ready_q,  ready_d;
    logic          byp_sel_q, byp_sel_d;
    T              byp_data_q;
    T              ram_rd_data;

    logic wr_en, can_load, mem_empty, bypass, rd_en, mem_wr;

    // Explicit wrap so non-power-of-two depths index only valid entries.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign wr_en     = receiver.valid && ready_q;
    assign can_load  = !valid_q || sender.ready;
    assign mem_empty = (fill_q == '0);
    assign bypass    = (BYPASS != 0) && mem_empty && wr_en && can_load && !flush;
    assign rd_en     = can_load && !mem_empty && !flush;
    assign mem_wr    = wr_en && !bypass && !flush;

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through
        // this block leaves one unassigned and no latch is inferred.
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        fill_d    = fill_q;
        valid_d   = valid_q;
        byp_sel_d = byp_sel_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
            valid_d  = 1'b0;
        end else begin
            if (mem_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_en)  rd_ptr_d = ptr_inc(rd_ptr_q);

            // Bypass never touches memory, so it leaves fill unchanged.
            case ({mem_wr, rd_en})
                2'b10:   fill_d = fill_q + LW'(1);
                2'b01:   fill_d = fill_q - LW'(1);
                default: fill_d = fill_q;
            endcase

            if (rd_en || bypass)   valid_d = 1'b1;
            else if (sender.ready) valid_d = 1'b0;

            // Output data comes from the RAM output register or the bypass
            // register; remember which one holds the current beat.
            if (rd_en)       byp_sel_d = 1'b0;
            else if (bypass) byp_sel_d = 1'b1;
        end

        // Registered ready: a read in a full cycle cannot admit a write
        // until the following cycle.
        ready_d = (fill_d < DEPTH_L);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
            byp_sel_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
            byp_sel_q <= byp_sel_d;
        end
    end

    always_ff @(posedge clock) begin
        if (bypass) begin
            byp_data_q <= receiver.data;
        end
    end

    sdpram #(
        .T     (T),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock     (clock),
        .wr_en_i   (mem_wr),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (receiver.data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_rd_data)
    );

    assign receiver.ready = ready_q;
    assign sender.valid   = valid_q;
    assign sender.data    = byp_sel_q ? byp_data_q : ram_rd_data;

    assign level        = fill_q + LW'(valid_q);
    assign almost_full  = (int'(level) >= AFULL);
    assign almost_empty = (int'(level) <= AEMPTY);

endmodule

// File: tb/tb_stream_fifo.sv
// -----------------------------------------------------------------------------
// tb_stream_fifo
// Three FIFO instances run side by side under shared control inputs:
//   u0: DEPTH=4, BYPASS=0 (AFULL=3)
//   u1: DEPTH=3, BYPASS=1 (AFULL=2)
//   u2: DEPTH=8, BYPASS=0, AFULL=6, AEMPTY=1
// A queue-based model of each FIFO is compared against every DUT output on
// every negative clock edge; directed literal checks pin key scenarios.
// -----------------------------------------------------------------------------
module tb_stream_fifo;

    localparam int NI = 3;

    int cfg_depth  [NI] = '{4, 3, 8};
    int cfg_byp    [NI] = '{0, 1, 0};
    int cfg_afull  [NI] = '{3, 2, 6};
    int cfg_aempty [NI] = '{1, 1, 1};

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        flush;
    logic        sready;
    logic        in_valid [NI];
    logic [31:0] din      [NI];

    stream rx0 (), tx0 (), rx1 (), tx1 (), rx2 (), tx2 ();

    logic [2:0] lvl0, lvl1;
    logic [3:0] lvl2;
    logic       af [NI];
    logic       ae [NI];

    stream_fifo #(.DEPTH(4), .BYPASS(0)) u0 (
        .clock(clock), .reset(reset), .flush(flush), .receiver(rx0), .sender(tx0),
        .level(lvl0), .almost_full(af[0]), .almost_empty(ae[0]));
    stream_fifo #(.DEPTH(3), .BYPASS(1)) u1 (
        .clock(clock), .reset(reset), .flush(flush), .receiver(rx1), .sender(tx1),
        .level(lvl1), .almost_full(af[1]), .almost_empty(ae[1]));
    stream_fifo #(.DEPTH(8), .BYPASS(0), .AFULL(6), .AEMPTY(1)) u2 (
        .clock(clock), .reset(reset), .flush(flush), .receiver(rx2), .sender(tx2),
        .level(lvl2), .almost_full(af[2]), .almost_empty(ae[2]));

    assign rx0.data = din[0];  assign rx0.valid = in_valid[0];  assign tx0.ready = sready;
    assign rx1.data = din[1];  assign rx1.valid = in_valid[1];  assign tx1.ready = sready;
    assign rx2.data = din[2];  assign rx2.valid = in_valid[2];  assign tx2.ready = sready;

    logic        o_rdy [NI];
    logic        o_val [NI];
    logic [31:0] o_dat [NI];
    int          o_lvl [NI];

    assign o_rdy[0] = rx0.ready;  assign o_val[0] = tx0.valid;  assign o_dat[0] = tx0.data;
    assign o_rdy[1] = rx1.ready;  assign o_val[1] = tx1.valid;  assign o_dat[1] = tx1.data;
    assign o_rdy[2] = rx2.ready;  assign o_val[2] = tx2.valid;  assign o_dat[2] = tx2.data;
    assign o_lvl[0] = 32'(lvl0);
    assign o_lvl[1] = 32'(lvl1);
    assign o_lvl[2] = 32'(lvl2);

    // ---------------- reference model ----------------
    logic [31:0] mq [NI][$];   // words waiting in memory, oldest first
    bit          m_ov  [NI];   // output register holds a beat
    logic [31:0] m_od  [NI];   // that beat
    bit          m_rdy [NI];   // receiver.ready for the coming cycle
    bit          m_wr  [NI];   // a beat was accepted at the last edge

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;
    bit sb_en    = 1'b0;
    bit seen77   = 1'b0;
    int exp_next [NI];
    int next_in  [NI];
    int max_lvl  [NI];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs held before it.
    task automatic model_update();
        bit wr, can_load, byp;
        for (int k = 0; k < NI; k++) begin
            m_wr[k] = 1'b0;
            if (!reset || flush) begin
                mq[k].delete();
                m_ov[k]  = 1'b0;
                m_rdy[k] = 1'b1;
            end else begin
                wr       = in_valid[k] && m_rdy[k];
                can_load = !m_ov[k] || sready;
                byp      = (cfg_byp[k] != 0) && (mq[k].size() == 0) && wr && can_load;
                if (can_load && mq[k].size() != 0) begin
                    m_od[k] = mq[k].pop_front();
                    m_ov[k] = 1'b1;
                end else if (byp) begin
                    m_od[k] = din[k];
                    m_ov[k] = 1'b1;
                end else if (sready) begin
                    m_ov[k] = 1'b0;
                end
                if (wr && !byp) mq[k].push_back(din[k]);
                m_rdy[k] = mq[k].size() < cfg_depth[k];
                m_wr[k]  = wr;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        model_update();
    endtask

    task automatic set_all(input logic v, input logic [31:0] d);
        for (int k = 0; k < NI; k++) begin
            in_valid[k] = v;
            din[k]      = d;
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // ---------------- per-cycle comparison ----------------
    always @(negedge clock) begin
        if (cmp_en) begin
            for (int k = 0; k < NI; k++) begin
                int lv;
                lv = mq[k].size() + int'(m_ov[k]);
                check($sformatf("u%0d.ready", k), 64'(o_rdy[k]), 64'(m_rdy[k]));
                check($sformatf("u%0d.valid", k), 64'(o_val[k]), 64'(m_ov[k]));
                if (m_ov[k]) check($sformatf("u%0d.data", k), 64'(o_dat[k]), 64'(m_od[k]));
                check($sformatf("u%0d.level", k), 64'(o_lvl[k]), 64'(lv));
                check($sformatf("u%0d.almost_full", k), 64'(af[k]), 64'(lv >= cfg_afull[k]));
                check($sformatf("u%0d.almost_empty", k), 64'(ae[k]), 64'(lv <= cfg_aempty[k]));
                if (o_lvl[k] > max_lvl[k]) max_lvl[k] = o_lvl[k];
                if (o_val[k] === 1'b1 && o_dat[k] === 32'h77) seen77 = 1'b1;
                if (sb_en && o_val[k] && sready) begin
                    check($sformatf("u%0d.order", k), 64'(o_dat[k]), 64'(exp_next[k]));
                    exp_next[k]++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, limit 2000000 expected never reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int acc0;
        bit done;
        reset  = 1'b0;
        flush  = 1'b0;
        sready = 1'b0;
        set_all(1'b0, 32'h0);

        // Reset held for 3 cycles.
        tick();
        cmp_en = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst u%0d.ready", k), 64'(o_rdy[k]), 64'd1);
            check($sformatf("rst u%0d.valid", k), 64'(o_val[k]), 64'd0);
            check($sformatf("rst u%0d.level", k), 64'(o_lvl[k]), 64'd0);
            check($sformatf("rst u%0d.almost_empty", k), 64'(ae[k]), 64'd1);
            check($sformatf("rst u%0d.almost_full", k), 64'(af[k]), 64'd0);
        end

        // Fill u0 (DEPTH=4) to capacity with the output stalled.
        acc0 = 0;
        for (int v = 1; v <= 7; v++) begin
            set_all(1'b1, 32'(v));
            if (o_rdy[0]) acc0++;
            tick();
        end
        check("fill accepted", 64'(acc0), 64'd5);
        check("fill ready", 64'(o_rdy[0]), 64'd0);
        check("fill level", 64'(o_lvl[0]), 64'd5);
        check("fill data", 64'(o_dat[0]), 64'd1);
        set_all(1'b1, 32'd6);
        sready = 1'b1;
        tick();
        sready = 1'b0;
        check("pulse ready back", 64'(o_rdy[0]), 64'd1);
        check("pulse level", 64'(o_lvl[0]), 64'd4);
        tick();
        check("word6 level", 64'(o_lvl[0]), 64'd5);
        check("word6 ready", 64'(o_rdy[0]), 64'd0);
        check("word6 head", 64'(o_dat[0]), 64'd2);
        set_all(1'b0, 32'd0);
        do_flush();

        // Latency from an empty FIFO.
        sready = 1'b1;
        set_all(1'b1, 32'hA5);
        tick();                       // accepted at edge n
        set_all(1'b0, 32'h0);
        check("lat byp valid n+1", 64'(o_val[1]), 64'd1);
        check("lat byp data n+1", 64'(o_dat[1]), 64'hA5);
        check("lat nobyp valid n+1", 64'(o_val[0]), 64'd0);
        tick();
        check("lat nobyp valid n+2", 64'(o_val[0]), 64'd1);
        check("lat nobyp data n+2", 64'(o_dat[0]), 64'hA5);
        tick();
        tick();

        // Thresholds on u2 (AFULL=6, AEMPTY=1).
        sready = 1'b0;
        do_flush();
        for (int i = 1; i <= 7; i++) begin
            set_all(1'b1, 32'(100 + i));
            tick();
            check($sformatf("thr up%0d level", i), 64'(o_lvl[2]), 64'(i));
            check($sformatf("thr up%0d af", i), 64'(af[2]), 64'(i >= 6));
            check($sformatf("thr up%0d ae", i), 64'(ae[2]), 64'(i <= 1));
        end
        set_all(1'b0, 32'h0);
        sready = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            tick();
            check($sformatf("thr dn%0d level", j), 64'(o_lvl[2]), 64'(7 - j));
            check($sformatf("thr dn%0d af", j), 64'(af[2]), 64'((7 - j) >= 6));
            check($sformatf("thr dn%0d ae", j), 64'(ae[2]), 64'((7 - j) <= 1));
        end

        // Flush mid-stream with u0 at level 3.
        sready = 1'b0;
        do_flush();
        for (int i = 1; i <= 3; i++) begin
            set_all(1'b1, 32'(i));
            tick();
        end
        check("pre-flush level", 64'(o_lvl[0]), 64'd3);
        seen77 = 1'b0;
        set_all(1'b1, 32'h77);
        do_flush();
        set_all(1'b0, 32'h0);
        check("flush level", 64'(o_lvl[0]), 64'd0);
        check("flush valid", 64'(o_val[0]), 64'd0);
        check("flush ready", 64'(o_rdy[0]), 64'd1);
        sready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("flush 0x77 dropped", 64'(seen77), 64'd0);

        // Random ordering/wrap: 0..99 through every instance.
        for (int k = 0; k < NI; k++) begin
            exp_next[k] = 0;
            next_in[k]  = 0;
            max_lvl[k]  = 0;
        end
        sb_en = 1'b1;
        done  = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            done = 1'b1;
            for (int k = 0; k < NI; k++) begin
                if (m_wr[k]) next_in[k]++;
                din[k]      = 32'(next_in[k]);
                in_valid[k] = (next_in[k] < 100) && ($urandom_range(0, 3) != 0);
                if (exp_next[k] < 100) done = 1'b0;
            end
            sready = ($urandom_range(0, 9) < 7);
            tick();
        end
        sb_en = 1'b0;
        set_all(1'b0, 32'h0);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("u%0d beats out", k), 64'(exp_next[k]), 64'd100);
        end
        check("u1 level bound", 64'(max_lvl[1] <= 4), 64'd1);
        tick();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
